vfifo_port_arbiter: RTL



---
 rtl/vfifo_pkg.sv | 11 +
 rtl/vfifo_rd_queue.sv | 47 ++++
 rtl/vfifo_port_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/vfifo_pkg.sv
// rtl/vfifo_pkg.sv - shared types and constants for the FIFO port arbiter slice
package vfifo_pkg;

   typedef enum logic {
      OWN_WR = 1'b0,
      OWN_RD = 1'b1
   } owner_t;

   localparam int RDQ_DEPTH = 2;

endpackage

// File: rtl/vfifo_rd_queue.sv
// rtl/vfifo_rd_queue.sv - small synchronous queue absorbing the RAM read latency
module vfifo_rd_queue
   import vfifo_pkg::*;
#(
   parameter int data_width = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [data_width-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            occ,
   output logic [data_width-1:0] head
);

   localparam int PTR_W = $clog2(RDQ_DEPTH);

   logic [data_width-1:0] mem [RDQ_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;

   // Storage carries no reset; pointers and occupancy define what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/vfifo_port_arbiter.sv
// rtl/vfifo_port_arbiter.sv - shares one FIFO RAM port between a write and a read client
module vfifo_port_arbiter
   import vfifo_pkg::*;
#(
   parameter int data_width = 18,
   parameter int max_burst  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   input  logic [data_width-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  rd_valid,
   output logic [data_width-1:0] rd_data,
   input  logic                  rd_ready,
   output logic                  fifo_wr,
   output logic [data_width-1:0] fifo_d,
   input  logic                  fifo_full,
   output logic                  fifo_rd,
   input  logic [data_width-1:0] fifo_q,
   input  logic                  fifo_empty
);

   localparam logic [3:0] BURST_MAX = 4'(max_burst);

   owner_t      owner;
   owner_t      grant_owner;
   logic [3:0]  burst_cnt;
   logic        inflight;
   logic [1:0]  occ;
   logic [2:0]  credit_use;
   logic        pop;
   logic        we_ok;
   logic        re_ok;
   logic        grant_wr;
   logic        grant_rd;

   assign rd_valid = (occ != 2'd0);
   assign pop      = rd_valid & rd_ready;

   // Slots committed after this cycle: queued words minus the pop plus the word still in the RAM pipe.
   assign credit_use = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

   assign we_ok = wr_valid & ~fifo_full;
   assign re_ok = ~fifo_empty & (credit_use < 3'd2);

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (!rst) begin
         if (we_ok && re_ok) begin
            // Owner keeps the port until its run reaches the limit, then yields.
            if ((owner == OWN_WR) == (burst_cnt < BURST_MAX)) begin
               grant_wr = 1'b1;
            end else begin
               grant_rd = 1'b1;
            end
         end else if (we_ok) begin
            grant_wr = 1'b1;
         end else if (re_ok) begin
            grant_rd = 1'b1;
         end
      end
   end

   assign grant_owner = grant_rd ? OWN_RD : OWN_WR;

   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWN_WR;
         burst_cnt <= 4'd0;
         inflight  <= 1'b0;
      end else begin
         inflight <= grant_rd;
         if (!grant_wr && !grant_rd) begin
            burst_cnt <= 4'd0;
         end else if (grant_owner == owner) begin
            burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 4'd1;
         end else begin
            owner     <= grant_owner;
            burst_cnt <= 4'd1;
         end
      end
   end

   assign fifo_wr  = grant_wr;
   assign wr_ready = grant_wr;
   assign fifo_rd  = grant_rd;
   assign fifo_d   = wr_data;

   vfifo_rd_queue #(
      .data_width(data_width)
   ) u_rd_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight),
      .push_data(fifo_q),
      .pop      (pop),
      .occ      (occ),
      .head     (rd_data)
   );

endmodule
